// File: rtl/fetch_unit.sv
// Instruction fetch unit: four-state fetch FSM, PC/IR registers and PC target selection.
// Optional macro FETCH_ALIGN_CHECK_EN blocks misaligned fetches and raises a sticky align_err.
module fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_ld,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] reg_target,
   output logic [31:0] imem_adr,
   input  logic [31:0] imem_dout,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic        busy,
   output logic        align_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_HOLD   = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;

   state_t      state;
   state_t      state_nx;
   logic        align_block;
   logic        fetch_go;
   logic        pc_load_en;
   logic        ir_load_en;
   logic [31:0] branch_off;
   logic [31:0] pc_target;

   // A misaligned PC only blocks a fetch when the check is compiled in.
`ifdef FETCH_ALIGN_CHECK_EN
   assign align_block = |pc[1:0];
`else
   assign align_block = 1'b0;
`endif

   // pc_ld has priority over fetch_start in IDLE; both are ignored elsewhere.
   assign fetch_go = fetch_start & ~pc_ld & ~align_block;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = fetch_go ? ADDR : IDLE;
         ADDR:    state_nx = LATCH;
         LATCH:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- output / control logic ----------------
   always_comb begin
      busy       = 1'b1;
      ir_valid   = 1'b0;
      ir_load_en = 1'b0;
      pc_load_en = 1'b0;
      case (state)
         IDLE: begin
            busy       = 1'b0;
            pc_load_en = pc_ld;
         end
         ADDR: begin
            busy = 1'b1;
         end
         LATCH: begin
            ir_load_en = 1'b1;
         end
         DONE: begin
            ir_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Branch offset is a signed word offset; PC already points past the branch.
   assign branch_off = {{14{ir[15]}}, ir[15:0], 2'b00};

   always_comb begin
      pc_target = pc;
      case (pc_sel)
         SEL_HOLD:   pc_target = pc;
         SEL_BRANCH: pc_target = pc + branch_off;
         SEL_JUMP:   pc_target = {pc[31:28], ir[25:0], 2'b00};
         default:    pc_target = reg_target;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= 32'd0;
      end else if (ir_load_en) begin
         pc <= pc + 32'd4;
      end else if (pc_load_en) begin
         pc <= pc_target;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir <= 32'd0;
      end else if (ir_load_en) begin
         ir <= imem_dout;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky until reset: records any fetch attempt refused for misalignment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         align_err <= 1'b0;
      end else if ((state == IDLE) && fetch_start && !pc_ld && align_block) begin
         align_err <= 1'b1;
      end
   end
`else
   assign align_err = 1'b0;
`endif

   assign imem_adr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of load/fetch/retarget vectors
// plus hand-written sequences for latency, overlap, reset and alignment cases.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        fetch_start;
   logic        pc_ld;
   logic [1:0]  pc_sel;
   logic [31:0] reg_target;
   logic [31:0] imem_adr;
   logic [31:0] imem_dout;
   logic [31:0] ir;
   logic        ir_valid;
   logic [31:0] pc;
   logic        busy;
   logic        align_err;

   logic [31:0] mem_adr;
   logic [31:0] mem_word;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_ld       (pc_ld),
      .pc_sel      (pc_sel),
      .reg_target  (reg_target),
      .imem_adr    (imem_adr),
      .imem_dout   (imem_dout),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .pc          (pc),
      .busy        (busy),
      .align_err   (align_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-location memory: any other address returns a poison word.
   always_comb imem_dout = (imem_adr == mem_adr) ? mem_word : 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] pc0;
      logic [31:0] word;
      logic [1:0]  sel;
      logic [31:0] reg_t;
      logic [31:0] pc_after;
      logic [31:0] pc_final;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load_pc(input logic [1:0] sel, input logic [31:0] tgt);
      pc_sel     = sel;
      reg_target = tgt;
      pc_ld      = 1'b1;
      tick();
      pc_ld      = 1'b0;
   endtask

   // Full fetch with cycle-accurate checks of busy/ir_valid/address/result.
   task automatic run_fetch(input string tag, input logic [31:0] exp_adr,
                            input logic [31:0] exp_ir, input logic [31:0] exp_pc);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check({tag, "_addr_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_imem_adr"}, imem_adr, exp_adr);
      tick();
      check({tag, "_latch_valid"}, {31'd0, ir_valid}, 32'd0);
      tick();
      check({tag, "_done_valid"}, {31'd0, ir_valid}, 32'd1);
      check({tag, "_ir"}, ir, exp_ir);
      check({tag, "_pc"}, pc, exp_pc);
      tick();
      check({tag, "_idle_valid"}, {31'd0, ir_valid}, 32'd0);
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int pulses;
      logic [31:0] ir_hold;

      // pc0, word, sel, reg_t, pc after fetch, pc after retarget
      vecs[0] = '{32'h0000_0008, 32'h1020_0004, 2'b01, 32'h0, 32'h0000_000C, 32'h0000_001C};
      vecs[1] = '{32'h0000_0018, 32'h1000_FFFB, 2'b01, 32'h0, 32'h0000_001C, 32'h0000_0008};
      vecs[2] = '{32'h1000_0000, 32'h0800_0005, 2'b10, 32'h0, 32'h1000_0004, 32'h1000_0014};
      vecs[3] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'b01, 32'h0, 32'h0000_0000, 32'h0001_59E0};
      vecs[4] = '{32'h0000_0100, 32'h0000_8000, 2'b01, 32'h0, 32'h0000_0104, 32'hFFFE_0104};
      vecs[5] = '{32'h0000_0040, 32'h03FF_FFFF, 2'b10, 32'h0, 32'h0000_0044, 32'h0FFF_FFFC};
      vecs[6] = '{32'h0000_0050, 32'h0000_0010, 2'b00, 32'h0, 32'h0000_0054, 32'h0000_0054};
      vecs[7] = '{32'h0000_0020, 32'hAABB_CCDD, 2'b11, 32'h1234_5670, 32'h0000_0024, 32'h1234_5670};

      // ---------------- reset ----------------
      rst         = 1'b0;
      fetch_start = 1'b0;
      pc_ld       = 1'b0;
      pc_sel      = 2'b00;
      reg_target  = 32'd0;
      mem_adr     = 32'd0;
      mem_word    = 32'h0000_5020;
      repeat (3) tick();
      check("rst_pc", pc, 32'd0);
      check("rst_ir", ir, 32'd0);
      check("rst_valid", {31'd0, ir_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_align", {31'd0, align_err}, 32'd0);
      rst = 1'b1;
      tick();

      // First fetch after reset reads address 0, result at N+2.
      run_fetch("first", 32'd0, 32'h0000_5020, 32'd4);

      // ---------------- table vectors ----------------
      for (int i = 0; i < 8; i++) begin
         load_pc(2'b11, vecs[i].pc0);
         check($sformatf("v%0d_load", i), pc, vecs[i].pc0);
         mem_adr  = vecs[i].pc0;
         mem_word = vecs[i].word;
         run_fetch($sformatf("v%0d", i), vecs[i].pc0, vecs[i].word, vecs[i].pc_after);
         load_pc(vecs[i].sel, vecs[i].reg_t);
         check($sformatf("v%0d_retarget", i), pc, vecs[i].pc_final);
      end

      // IR holds between fetches while memory output changes.
      ir_hold  = ir;
      mem_word = 32'h5555_AAAA;
      repeat (3) tick();
      check("ir_hold", ir, ir_hold);

      // ---------------- fetch_start held while busy ----------------
      load_pc(2'b11, 32'h0000_0200);
      mem_adr  = 32'h0000_0200;
      mem_word = 32'h0F0F_0F0F;
      pulses   = 0;
      fetch_start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ir_valid) pulses++;
      end
      fetch_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ir_valid) pulses++;
      end
      check("held_pulses", pulses, 1);
      check("held_pc", pc, 32'h0000_0204);
      check("held_ir", ir, 32'h0F0F_0F0F);

      // ---------------- pc_ld and fetch_start together ----------------
      fetch_start = 1'b1;
      load_pc(2'b11, 32'h0000_0080);
      fetch_start = 1'b0;
      check("both_pc", pc, 32'h0000_0080);
      check("both_busy", {31'd0, busy}, 32'd0);
      tick();
      check("both_busy2", {31'd0, busy}, 32'd0);

      // ---------------- pc_ld while busy is ignored ----------------
      mem_adr  = 32'h0000_0080;
      mem_word = 32'h7777_0001;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      pc_sel      = 2'b11;
      reg_target  = 32'h0000_0999;
      pc_ld       = 1'b1;
      repeat (3) tick();
      pc_ld = 1'b0;
      check("busy_ld_pc", pc, 32'h0000_0084);
      check("busy_ld_ir", ir, 32'h7777_0001);

      // ---------------- reset asserted in LATCH ----------------
      mem_adr  = 32'h0000_0084;
      mem_word = 32'h3333_4444;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("latch_rst_pc", pc, 32'd0);
      check("latch_rst_ir", ir, 32'd0);
      check("latch_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (ir_valid) pulses++;
      end
      check("latch_rst_pulses", pulses, 0);
      check("latch_rst_ir2", ir, 32'd0);

      // ---------------- misaligned PC ----------------
      load_pc(2'b11, 32'h0000_0006);
      mem_adr  = 32'h0000_0006;
      mem_word = 32'hCAFE_F00D;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      check("align_busy", {31'd0, busy}, 32'd0);
      check("align_err", {31'd0, align_err}, 32'd1);
      repeat (2) tick();
      check("align_sticky", {31'd0, align_err}, 32'd1);
      check("align_pc", pc, 32'h0000_0006);
`else
      run_fetch("misalign", 32'h0000_0006, 32'hCAFE_F00D, 32'h0000_000A);
      check("align_err", {31'd0, align_err}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock and one asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 fetch_start  input  1  request to fetch the instruction at the current PC; sampled only in IDLE.
REQ-005 pc_ld  input  1  load a new PC value, selected by pc_sel; sampled only in IDLE.
REQ-006 pc_sel  input  2  PC source: 00 no change, 01 branch target, 10 jump target, 11 reg_target.
REQ-007 reg_target  input  32  register-sourced PC target, used for jr.
REQ-008 imem_adr  output  32  instruction-memory byte address; combinationally equal to PC.
REQ-009 imem_dout  input  32  instruction word from combinational instruction memory, byte 0 in bits [7:0].
REQ-010 ir  output  32  instruction register.
REQ-011 ir_valid  output  1  one-cycle pulse the cycle after IR is loaded.
REQ-012 pc  output  32  current PC.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 align_err  output  1  sticky misalignment flag; present only with the configuration macro defined.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, LATCH, DONE.
REQ-016 IDLE, with fetch_start=1 and pc_ld=0 -> ADDR; all other cases stay in IDLE.
REQ-017 ADDR: imem_adr held stable for the memory to settle; unconditional -> LATCH.
REQ-018 LATCH: IR <= imem_dout and PC <= PC+4 (mod 2^32, wrap 0xFFFFFFFC -> 0); -> DONE.
REQ-019 DONE: ir_valid=1 for exactly this cycle; -> IDLE.
REQ-020 Latency: fetch_start sampled at edge N -> IR/PC updated at edge N+2 -> ir_valid high during cycle N+2 to N+3.
REQ-021 Back-to-back fetches: the next fetch_start is accepted in IDLE, giving a 4-cycle minimum fetch period.
REQ-022 fetch_start while busy SHALL be ignored, not queued.
REQ-023 pc_ld in IDLE SHALL update PC at the next edge; pc_sel=00 leaves PC unchanged.
REQ-024 Branch target (pc_sel=01) = PC + (sign_extend(IR[15:0]) << 2), 32-bit truncating add; PC already holds the incremented value.
REQ-025 Jump target (pc_sel=10) = {PC[31:28], IR[25:0], 2'b00}.
REQ-026 pc_ld and fetch_start asserted together in IDLE: pc_ld wins and fetch_start is dropped.
REQ-027 pc_ld while busy SHALL be ignored.
REQ-028 IR SHALL hold its value between fetches.

Reset
REQ-029 Reset asserted at any time, including mid-fetch, forces: state IDLE, PC=0, IR=0, ir_valid=0, busy=0, align_err=0.
REQ-030 After reset deassertion, the first accepted fetch reads address 0.

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN.
- Defined: fetch_start in IDLE with PC[1:0]!=0 does not start a fetch; it sets align_err, which is cleared only by reset.
- Undefined: no alignment check; PC[1:0] passes to imem_adr unchanged; align_err is tied to 0.

Verification
REQ-032 Reset, then fetch_start with imem returning 0x00005020 -> ir=0x00005020, pc=4, ir_valid pulse at cycle N+2.
REQ-033 PC=8, imem=0x10200004 -> after fetch pc=12; pc_ld with pc_sel=01 -> pc=28.
REQ-034 PC=24, imem=0x1000FFFB -> after fetch pc=28; pc_ld with pc_sel=01 -> pc=8.
REQ-035 PC=0x10000000, imem=0x08000005 -> fetch gives pc=0x10000004; pc_sel=10 -> pc=0x10000014.
REQ-036 Overlapping and simultaneous events:
- fetch_start held during busy -> exactly one fetch.
- pc_ld and fetch_start together -> PC loaded, busy stays 0.
- Reset asserted in LATCH -> pc=0, ir=0, no ir_valid.
REQ-037 Alignment check:
- With FETCH_ALIGN_CHECK_EN: pc_ld reg_target=0x6, then fetch_start -> align_err=1, busy stays 0.
- Without the macro: the same stimulus fetches from 0x6, and align_err=0.
